auto_exposure_controller: RTL
=============================

# auto_exposure_controller

Closed-loop exposure controller for the camera clock domain. It accumulates per-frame luma from the pixel stream and, at frame end, compares the frame mean against a target band. It then steps an 8-bit exposure value and pulses a single-cycle update request into the camera configurator, which writes sensor registers 0x3501/0x3502/0x3503 over I2C. A manual mode passes a host-supplied exposure straight through, using the same request handshake.

## Interface
- FRAME_PIXELS, 57600: valid pixels per complete frame (180x320).
- TARGET_LUMA, 96: target mean luma, 0..255.
- HYST, 8: half-width of the dead band around the target.
- FAR, 32: distance from the target beyond which the large step applies; must be greater than HYST.
- STEP_SMALL, 2; STEP_LARGE, 16: exposure increments.
- EXP_MIN, 1; EXP_INIT, 128: exposure floor and reset value. The ceiling is 255.
- SETTLE_FRAMES, 2: complete frames skipped after each request.
- clk_camera  in  1  camera-domain clock.
- sys_rst_camera_n  in  1  reset, asynchronous assert, active-low.
- frame_start  in  1  one-cycle pulse at the start of a frame.
- frame_end  in  1  one-cycle pulse after, or with, the last pixel.
- pixel_valid  in  1  qualifies pixel_luma.
- pixel_luma  in  8  pixel luminance.
- ae_enable  in  1  1 = closed loop; 0 = manual pass-through.
- manual_exposure_in  in  8  exposure used when ae_enable=0.
- sensor_aec  in  1  1 = sensor's own AEC.
- cfg_busy  in  1  configurator or I2C bus busy; holds off requests.
- exposure  out  8  exposure value consumed by the configurator.
- manual_exposure  out  1  = ~sensor_aec, registered.
- ready_update_out  out  1  one-cycle update request.
- dropped_frames  out  8  saturating count of rejected frames.

## Operation
- Accumulator (independent of the FSM):
  - Sum width is clog2(255*FRAME_PIXELS+1). The count saturates at FRAME_PIXELS+1.
  - frame_start clears the sum and count. A pixel_valid in the same cycle is counted into the new frame.
  - Each pixel_valid adds pixel_luma and increments the count.
- Frame judgement on frame_end:
  - A frame is accepted if count==FRAME_PIXELS and a frame_start has been seen since reset.
  - A rejected frame increments dropped_frames (saturating at 255) and is never evaluated.
  - The sum is latched at frame_end; a frame_end coincident with pixel_valid includes that pixel.
- Thresholds are elaboration-time constants, computed from (TARGET_LUMA ± HYST)*FRAME_PIXELS and (TARGET_LUMA ± FAR)*FRAME_PIXELS. Each is clamped to the range 0..255*FRAME_PIXELS.
- Step selection, in priority order:
  - sum < FAR_LO: +STEP_LARGE.
  - sum < LO: +STEP_SMALL.
  - sum > FAR_HI: −STEP_LARGE.
  - sum > HI: −STEP_SMALL.
  - Otherwise: no change.
  - The result is computed 10 bits wide, then saturated to [EXP_MIN, 255].
- FSM states IDLE, EVAL, REQUEST, HOLDOFF:
  - IDLE, ae_enable=1: an accepted frame_end goes to EVAL if the settle counter is 0. If the counter is nonzero, it decrements and the FSM stays in IDLE.
  - IDLE, ae_enable=0: if manual_exposure_in≠exposure, or sensor_aec changed since the last request, load exposure and go to REQUEST.
  - EVAL: apply the step. Go to REQUEST if exposure changed, else to IDLE.
  - REQUEST: wait while cfg_busy=1. When cfg_busy=0, assert ready_update_out for one cycle, load the settle counter with SETTLE_FRAMES, and go to HOLDOFF.
  - HOLDOFF: 3 cycles, matching the 3-cycle register-write burst, then go to IDLE.
- A frame_end arriving outside IDLE is judged (dropped_frames may change) but not evaluated, and it does not decrement the settle counter.
- exposure and manual_exposure are frozen outside IDLE and EVAL.
- ae_enable or sensor_aec toggling mid-request takes effect at the next IDLE.

## Timing
- Reset values:
  - exposure=EXP_INIT, manual_exposure=1, ready_update_out=0, dropped_frames=0.
  - FSM=IDLE, settle counter=0, sum and count cleared, no frame_start seen.
- No request is issued on reset release.
- With frame_end sampled in cycle T, cfg_busy=0, and a change made:
  - EVAL occurs in T+1.
  - The new exposure is visible in T+2.
  - ready_update_out is high in T+2 only.
  - HOLDOFF covers T+3..T+5.
  - The FSM is back in IDLE at T+6.
- Manual change sampled in IDLE at cycle T: exposure updates in T+1; ready_update_out rises in T+1 at the earliest.
- Every ready_update_out pulse lasts exactly 1 cycle. Consecutive pulses are at least 5 cycles apart.
- Reset asserted mid-operation: all outputs take their reset values immediately. A pending request is discarded.

## Test plan
- Bench parameters: FRAME_PIXELS=64, TARGET=96, HYST=8, FAR=32, STEP_SMALL=2, STEP_LARGE=16, SETTLE_FRAMES=2, EXP_INIT=128.
- 64 pixels of luma 0x10, cfg_busy=0 -> exposure 128→144 at T+2; exactly one ready_update_out, in T+2.
- Luma 100 for three consecutive frames -> no request and exposure stays 128. Then luma 80: the first evaluated frame gives 130.
- Luma 255 repeated -> exposure falls by 16 on every third accepted frame (settle), then saturates at EXP_MIN=1 with no further requests.
- Frame with 63 pixels -> dropped_frames=1, no request. Then cfg_busy=1 held for 20 cycles during REQUEST -> the pulse appears on the first cycle cfg_busy=0.
- ae_enable=0, manual_exposure_in=0x3C -> exposure=0x3C, one pulse. Toggling sensor_aec -> manual_exposure=0, one pulse. Asserting reset mid-HOLDOFF -> exposure=128 and no pulse afterwards.

Source files
------------

// File: rtl/auto_exposure_controller_if.sv
// Camera-domain bundle between the pixel pipe / host side and the exposure controller.
// The master side drives the pixel stream, mode controls and configurator status;
// the slave side (the controller) returns the exposure, AEC mode and update request.
interface auto_exposure_controller_if;
    logic       frame_start;
    logic       frame_end;
    logic       pixel_valid;
    logic [7:0] pixel_luma;
    logic       ae_enable;
    logic [7:0] manual_exposure_in;
    logic       sensor_aec;
    logic       cfg_busy;
    logic [7:0] exposure;
    logic       manual_exposure;
    logic       ready_update_out;
    logic [7:0] dropped_frames;

    modport master (
        output frame_start,
        output frame_end,
        output pixel_valid,
        output pixel_luma,
        output ae_enable,
        output manual_exposure_in,
        output sensor_aec,
        output cfg_busy,
        input  exposure,
        input  manual_exposure,
        input  ready_update_out,
        input  dropped_frames
    );

    modport slave (
        input  frame_start,
        input  frame_end,
        input  pixel_valid,
        input  pixel_luma,
        input  ae_enable,
        input  manual_exposure_in,
        input  sensor_aec,
        input  cfg_busy,
        output exposure,
        output manual_exposure,
        output ready_update_out,
        output dropped_frames
    );
endinterface

// File: rtl/auto_exposure_controller.sv
// Closed-loop auto exposure controller (camera clock domain).
// Accumulates per-frame luma, judges complete frames, steps an 8-bit exposure toward a
// target band and issues a one-cycle update request to the sensor configurator.
// Manual mode passes a host exposure through using the same request handshake.
module auto_exposure_controller #(
    parameter int unsigned FRAME_PIXELS  = 57600,
    parameter int unsigned TARGET_LUMA   = 96,
    parameter int unsigned HYST          = 8,
    parameter int unsigned FAR           = 32,
    parameter int unsigned STEP_SMALL    = 2,
    parameter int unsigned STEP_LARGE    = 16,
    parameter int unsigned EXP_MIN       = 1,
    parameter int unsigned EXP_INIT      = 128,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input logic                        clk_camera,
    input logic                        sys_rst_camera_n,
    auto_exposure_controller_if.slave  ae
);

    localparam int unsigned SUM_W    = $clog2(255 * FRAME_PIXELS + 1);
    localparam int unsigned CNT_W    = $clog2(FRAME_PIXELS + 2);
    localparam int unsigned SETTLE_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

    localparam longint MAX_SUM = longint'(255) * longint'(FRAME_PIXELS);

    function automatic longint clamp_thr(input longint v, input longint hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    localparam longint FAR_LO_L = clamp_thr(
        (longint'(TARGET_LUMA) - longint'(FAR)) * longint'(FRAME_PIXELS), MAX_SUM);
    localparam longint LO_L = clamp_thr(
        (longint'(TARGET_LUMA) - longint'(HYST)) * longint'(FRAME_PIXELS), MAX_SUM);
    localparam longint HI_L = clamp_thr(
        (longint'(TARGET_LUMA) + longint'(HYST)) * longint'(FRAME_PIXELS), MAX_SUM);
    localparam longint FAR_HI_L = clamp_thr(
        (longint'(TARGET_LUMA) + longint'(FAR)) * longint'(FRAME_PIXELS), MAX_SUM);

    localparam logic [SUM_W-1:0] THR_FAR_LO = SUM_W'(FAR_LO_L);
    localparam logic [SUM_W-1:0] THR_LO     = SUM_W'(LO_L);
    localparam logic [SUM_W-1:0] THR_HI     = SUM_W'(HI_L);
    localparam logic [SUM_W-1:0] THR_FAR_HI = SUM_W'(FAR_HI_L);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_PIXELS + 1);

    localparam logic signed [9:0] STEP_S   = 10'(STEP_SMALL);
    localparam logic signed [9:0] STEP_L   = 10'(STEP_LARGE);
    localparam logic signed [9:0] EXP_MINS = 10'(EXP_MIN);
    localparam logic signed [9:0] EXP_MAXS = 10'sd255;

    // HOLDOFF spans three cycles: counter runs 2, 1, 0.
    localparam logic [1:0] HOLD_LOAD = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StRequest,
        StHoldoff
    } state_e;

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    sum_q, sum_d, sum_base;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base;
    logic                started_q, started_d;
    logic [SUM_W-1:0]    sum_lat_q, sum_lat_d;
    logic [7:0]          dropped_q, dropped_d;
    logic [7:0]          exp_q, exp_d;
    logic                man_q, man_d;
    logic                aec_last_q, aec_last_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [1:0]          hold_q, hold_d;
    logic                ready;
    logic                frame_ok;
    logic                frame_bad;
    logic signed [9:0]   step;
    logic signed [9:0]   exp_wide;
    logic [7:0]          exp_sat;

    // Pixel accumulator and frame judgement; runs regardless of FSM state.
    always_comb begin
        sum_base  = ae.frame_start ? '0 : sum_q;
        cnt_base  = ae.frame_start ? '0 : cnt_q;
        sum_d     = sum_base;
        cnt_d     = cnt_base;
        started_d = started_q | ae.frame_start;
        if (ae.pixel_valid) begin
            // Pixels beyond a full frame only push the count to its saturation value,
            // so the sum never exceeds the full-frame maximum.
            if (cnt_base < CNT_FULL) begin
                sum_d = sum_base + SUM_W'(ae.pixel_luma);
            end
            if (cnt_base != CNT_SAT) begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
        frame_ok  = ae.frame_end && started_d && (cnt_d == CNT_FULL);
        frame_bad = ae.frame_end && !frame_ok;
        sum_lat_d = frame_ok ? sum_d : sum_lat_q;
        dropped_d = dropped_q;
        if (frame_bad && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // Step selection from the latched frame sum, saturated to [EXP_MIN, 255].
    always_comb begin
        step = '0;
        if (sum_lat_q < THR_FAR_LO) begin
            step = STEP_L;
        end else if (sum_lat_q < THR_LO) begin
            step = STEP_S;
        end else if (sum_lat_q > THR_FAR_HI) begin
            step = -STEP_L;
        end else if (sum_lat_q > THR_HI) begin
            step = -STEP_S;
        end
        exp_wide = signed'({2'b00, exp_q}) + step;
        if (exp_wide > EXP_MAXS) begin
            exp_sat = 8'hFF;
        end else if (exp_wide < EXP_MINS) begin
            exp_sat = 8'(EXP_MIN);
        end else begin
            exp_sat = exp_wide[7:0];
        end
    end

    // Control FSM: next state, exposure/mode updates and the update request.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        man_d      = man_q;
        aec_last_d = aec_last_q;
        settle_d   = settle_q;
        hold_d     = hold_q;
        ready      = 1'b0;
        case (state_q)
            StIdle: begin
                man_d = ~ae.sensor_aec;
                if (ae.ae_enable) begin
                    if (frame_ok) begin
                        if (settle_q == '0) begin
                            state_d = StEval;
                        end else begin
                            settle_d = settle_q - SETTLE_W'(1);
                        end
                    end
                end else if ((ae.manual_exposure_in != exp_q) ||
                             (ae.sensor_aec != aec_last_q)) begin
                    exp_d      = ae.manual_exposure_in;
                    aec_last_d = ae.sensor_aec;
                    state_d    = StRequest;
                end
            end
            StEval: begin
                man_d = ~ae.sensor_aec;
                if (exp_sat != exp_q) begin
                    exp_d      = exp_sat;
                    aec_last_d = ae.sensor_aec;
                    state_d    = StRequest;
                end else begin
                    state_d = StIdle;
                end
            end
            StRequest: begin
                if (!ae.cfg_busy) begin
                    ready    = 1'b1;
                    settle_d = SETTLE_W'(SETTLE_FRAMES);
                    hold_d   = HOLD_LOAD;
                    state_d  = StHoldoff;
                end
            end
            StHoldoff: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            state_q    <= StIdle;
            sum_q      <= '0;
            cnt_q      <= '0;
            started_q  <= 1'b0;
            sum_lat_q  <= '0;
            dropped_q  <= '0;
            exp_q      <= 8'(EXP_INIT);
            man_q      <= 1'b1;
            aec_last_q <= 1'b0;
            settle_q   <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            started_q  <= started_d;
            sum_lat_q  <= sum_lat_d;
            dropped_q  <= dropped_d;
            exp_q      <= exp_d;
            man_q      <= man_d;
            aec_last_q <= aec_last_d;
            settle_q   <= settle_d;
            hold_q     <= hold_d;
        end
    end

    assign ae.exposure         = exp_q;
    assign ae.manual_exposure  = man_q;
    assign ae.ready_update_out = ready;
    assign ae.dropped_frames   = dropped_q;

endmodule
